// File: rtl/write_select_decoder.sv
// write_select_decoder: registered one-hot write-select decoder. It decodes a
// single index on request, or sweeps every index 0..OUT_W-1 once, one per
// cycle. The top index (XZR) can be write-suppressed: in that case it yields an
// all-zero select that is flagged as masked.
module write_select_decoder #(
  parameter int SEL_W    = 5,
  parameter bit MASK_TOP = 1'b1,
  localparam int OUT_W   = 1 << SEL_W
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [SEL_W-1:0] S,
  input  logic             en,
  input  logic             sweep_start,
  output logic [OUT_W-1:0] m,
  output logic             valid,
  output logic             masked,
  output logic             busy,
  output logic             sweep_done
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // cnt is one bit wider than an index so it can hold OUT_W. That value marks
  // the drain cycle: the last sweep result is still on the outputs and busy is
  // still high, so requests made in that cycle must be ignored.
  localparam logic [SEL_W:0] CNT_LAST = (SEL_W+1)'(OUT_W - 1);
  localparam logic [SEL_W:0] CNT_END  = (SEL_W+1)'(OUT_W);
  localparam logic [SEL_W:0] CNT_ONE  = (SEL_W+1)'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W:0]   r_cnt;
  logic [SEL_W:0]   w_cnt_nxt;
  logic             w_fire;
  logic [SEL_W-1:0] w_idx;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_top;
  logic             w_hide;
  logic [OUT_W-1:0] w_m_nxt;

  logic [OUT_W-1:0] r_m;
  logic             r_valid;
  logic             r_masked;
  logic             r_busy;
  logic             r_done;

  // Next-state logic: choose which index (if any) is emitted on the next edge.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    w_idx       = '0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sweep_start) begin
          // A sweep wins over a simultaneous decode; the decode is dropped.
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = CNT_ONE;
          w_fire      = 1'b1;
          w_busy_nxt  = 1'b1;
        end else if (en) begin
          w_fire = 1'b1;
          w_idx  = S;
        end
      end
      ST_SWEEP: begin
        if (r_cnt == CNT_END) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_fire     = 1'b1;
          w_idx      = r_cnt[SEL_W-1:0];
          w_cnt_nxt  = r_cnt + CNT_ONE;
          w_busy_nxt = 1'b1;
          w_done_nxt = (r_cnt == CNT_LAST);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output data: one-hot of the chosen index, or zero when nothing fires or the
  // top index is suppressed.
  always_comb begin
    w_top   = w_fire && (w_idx == {SEL_W{1'b1}});
    w_hide  = MASK_TOP && w_top;
    w_m_nxt = '0;
    if (w_fire && !w_hide) begin
      w_m_nxt[w_idx] = 1'b1;
    end
  end

  // State, counter and output registers, with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge, whatever the order.
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_m      <= '0;
      r_valid  <= 1'b0;
      r_masked <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_m      <= w_m_nxt;
      r_valid  <= w_fire;
      r_masked <= w_hide;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign m          = r_m;
  assign valid      = r_valid;
  assign masked     = r_masked;
  assign busy       = r_busy;
  assign sweep_done = r_done;

endmodule

// File: tb/tb_write_select_decoder.sv
// tb_write_select_decoder: directed scenarios on a SEL_W=5 decoder (masked and
// unmasked), then a random stream run on several widths against a cycle-level
// model of the decoder's behaviour.
module tb_write_select_decoder;

  localparam int NDUT = 5;
  localparam int SEL_W_TAB [NDUT] = '{5, 5, 1, 3, 8};
  localparam bit MASK_TAB  [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  typedef struct packed {
    logic [255:0] m;
    logic         valid;
    logic         masked;
    logic         busy;
    logic         done;
  } exp_t;

  logic       CLK;
  logic       reset;
  logic       en;
  logic       sweep_start;
  logic [7:0] s_bus;

  wire [31:0]  m0;
  wire [31:0]  m1;
  wire [1:0]   m2;
  wire [7:0]   m3;
  wire [255:0] m4;
  wire [NDUT-1:0] valid_w;
  wire [NDUT-1:0] masked_w;
  wire [NDUT-1:0] busy_w;
  wire [NDUT-1:0] done_w;

  wire [3:0] st0 = {valid_w[0], masked_w[0], busy_w[0], done_w[0]};
  wire [3:0] st1 = {valid_w[1], masked_w[1], busy_w[1], done_w[1]};

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: position of the next sweep index per DUT (-1 = not sweeping).
  int   sw_pos [NDUT];
  exp_t exp_q  [NDUT];

  write_select_decoder #(.SEL_W(5), .MASK_TOP(1'b1)) u_d0 (
    .CLK(CLK), .reset(reset), .S(s_bus[4:0]), .en(en), .sweep_start(sweep_start),
    .m(m0), .valid(valid_w[0]), .masked(masked_w[0]), .busy(busy_w[0]), .sweep_done(done_w[0]));
  write_select_decoder #(.SEL_W(5), .MASK_TOP(1'b0)) u_d1 (
    .CLK(CLK), .reset(reset), .S(s_bus[4:0]), .en(en), .sweep_start(sweep_start),
    .m(m1), .valid(valid_w[1]), .masked(masked_w[1]), .busy(busy_w[1]), .sweep_done(done_w[1]));
  write_select_decoder #(.SEL_W(1), .MASK_TOP(1'b1)) u_d2 (
    .CLK(CLK), .reset(reset), .S(s_bus[0:0]), .en(en), .sweep_start(sweep_start),
    .m(m2), .valid(valid_w[2]), .masked(masked_w[2]), .busy(busy_w[2]), .sweep_done(done_w[2]));
  write_select_decoder #(.SEL_W(3), .MASK_TOP(1'b1)) u_d3 (
    .CLK(CLK), .reset(reset), .S(s_bus[2:0]), .en(en), .sweep_start(sweep_start),
    .m(m3), .valid(valid_w[3]), .masked(masked_w[3]), .busy(busy_w[3]), .sweep_done(done_w[3]));
  write_select_decoder #(.SEL_W(8), .MASK_TOP(1'b0)) u_d4 (
    .CLK(CLK), .reset(reset), .S(s_bus), .en(en), .sweep_start(sweep_start),
    .m(m4), .valid(valid_w[4]), .masked(masked_w[4]), .busy(busy_w[4]), .sweep_done(done_w[4]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit r, input bit e, input bit sw, input logic [7:0] s);
    reset       = r;
    en          = e;
    sweep_start = sw;
    s_bus       = s;
  endtask

  function automatic logic [255:0] get_m(input int d);
    case (d)
      0: return 256'(m0);
      1: return 256'(m1);
      2: return 256'(m2);
      3: return 256'(m3);
      default: return m4;
    endcase
  endfunction

  // Expected result of emitting index k on DUT d.
  function automatic exp_t emit(input int d, input int k, input bit in_sweep);
    exp_t e;
    int   top;
    top      = (1 << SEL_W_TAB[d]) - 1;
    e        = '0;
    e.valid  = 1'b1;
    e.busy   = in_sweep;
    e.done   = in_sweep && (k == top);
    if (MASK_TAB[d] && (k == top)) e.masked = 1'b1;
    else e.m[k] = 1'b1;
    return e;
  endfunction

  // Predict every DUT's outputs after the coming edge from the current inputs.
  task automatic model_step();
    for (int d = 0; d < NDUT; d++) begin
      int ow;
      int s;
      ow = 1 << SEL_W_TAB[d];
      s  = int'(s_bus) & (ow - 1);
      if (reset) begin
        sw_pos[d] = -1;
        exp_q[d]  = '0;
      end else if (sw_pos[d] >= 0) begin
        if (sw_pos[d] == ow) begin
          // Last sweep result is still showing with busy high: inputs ignored.
          exp_q[d]  = '0;
          sw_pos[d] = -1;
        end else begin
          exp_q[d]  = emit(d, sw_pos[d], 1'b1);
          sw_pos[d] = sw_pos[d] + 1;
        end
      end else if (sweep_start) begin
        exp_q[d]  = emit(d, 0, 1'b1);
        sw_pos[d] = 1;
      end else if (en) begin
        exp_q[d] = emit(d, s, 1'b0);
      end else begin
        exp_q[d] = '0;
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 8'd7);
    tick();
    n_checks++;
    if ({m0, st0} !== {32'h0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_dut0 got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h0, 4'b0000);
    end
    n_checks++;
    if ({m4, valid_w[4], busy_w[4]} !== {256'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_dut4 got m=%h v=%b b=%b exp all zero", m4, valid_w[4], busy_w[4]);
    end
    drive(1'b0, 1'b1, 1'b0, 8'd7);
    tick();
    n_checks++;
    if ({m0, st0} !== {32'h0000_0080, 4'b1000}) begin
      n_fail++;
      $display("FAIL first_en_after_reset got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h80, 4'b1000);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd7);
    tick();
    n_checks++;
    if ({m0, st0} !== {32'h0, 4'b0000}) begin
      n_fail++;
      $display("FAIL idle_no_en got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h0, 4'b0000);
    end
  endtask

  task automatic test_decode();
    logic [31:0] exp_m;
    int          s;
    drive(1'b0, 1'b1, 1'b0, 8'd31);
    tick();
    n_checks++;
    if ({m0, st0} !== {32'h0, 4'b1100}) begin
      n_fail++;
      $display("FAIL mask_top_on got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h0, 4'b1100);
    end
    n_checks++;
    if ({m1, st1} !== {32'h8000_0000, 4'b1000}) begin
      n_fail++;
      $display("FAIL mask_top_off got m=%h st=%b exp m=%h st=%b", m1, st1, 32'h8000_0000, 4'b1000);
    end
    drive(1'b0, 1'b1, 1'b0, 8'd0);
    tick();
    n_checks++;
    if ({m0, st0} !== {32'h1, 4'b1000}) begin
      n_fail++;
      $display("FAIL decode_idx0 got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h1, 4'b1000);
    end
    for (int i = 0; i < 8; i++) begin
      s = int'($urandom_range(0, 30));
      drive(1'b0, 1'b1, 1'b0, 8'(s));
      tick();
      exp_m = 32'd1 << s;
      n_checks++;
      if ({m0, st0} !== {exp_m, 4'b1000}) begin
        n_fail++;
        $display("FAIL back_to_back S=%0d got m=%h st=%b exp m=%h st=%b", s, m0, st0, exp_m, 4'b1000);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'd31);
    tick();
    n_checks++;
    if ({m0, st0} !== {32'h0, 4'b0000}) begin
      n_fail++;
      $display("FAIL idle_top_sel got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h0, 4'b0000);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] exp_m;
    logic [3:0]  exp_st;
    drive(1'b0, 1'b0, 1'b1, 8'd9);
    for (int k = 0; k < 32; k++) begin
      tick();
      exp_m  = (k == 31) ? 32'h0 : (32'd1 << k);
      exp_st = {1'b1, (k == 31), 1'b1, (k == 31)};
      n_checks++;
      if ({m0, st0} !== {exp_m, exp_st}) begin
        n_fail++;
        $display("FAIL sweep k=%0d got m=%h st=%b exp m=%h st=%b", k, m0, st0, exp_m, exp_st);
      end
      if (k == 31) begin
        n_checks++;
        if ({m1, st1} !== {32'h8000_0000, 4'b1011}) begin
          n_fail++;
          $display("FAIL sweep_last_unmasked got m=%h st=%b exp m=%h st=%b", m1, st1, 32'h8000_0000, 4'b1011);
        end
        drive(1'b0, 1'b1, 1'b1, 8'd5);
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end
    end
    tick();
    n_checks++;
    if ({m0, st0} !== {32'h0, 4'b0000}) begin
      n_fail++;
      $display("FAIL sweep_drain_ignored got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h0, 4'b0000);
    end
    drive(1'b0, 1'b1, 1'b0, 8'd5);
    tick();
    n_checks++;
    if ({m0, st0} !== {32'h20, 4'b1000}) begin
      n_fail++;
      $display("FAIL after_sweep_accept got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h20, 4'b1000);
    end
  endtask

  task automatic test_collision();
    logic [31:0] exp_m;
    drive(1'b0, 1'b1, 1'b1, 8'd3);
    for (int k = 0; k < 32; k++) begin
      tick();
      exp_m = (k == 31) ? 32'h0 : (32'd1 << k);
      n_checks++;
      if ({m0, busy_w[0]} !== {exp_m, 1'b1}) begin
        n_fail++;
        $display("FAIL collision k=%0d got m=%h busy=%b exp m=%h busy=1", k, m0, busy_w[0], exp_m);
      end
      drive(1'b0, 1'b1, 1'b0, 8'd3);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    n_checks++;
    if ({m0, st0} !== {32'h0, 4'b0000}) begin
      n_fail++;
      $display("FAIL collision_no_queue got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h0, 4'b0000);
    end
  endtask

  task automatic test_reset_mid_sweep();
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c < 10) drive(1'b0, 1'b0, 1'b0, 8'd0);
      else drive(1'b1, 1'b0, 1'b0, 8'd0);
    end
    n_checks++;
    if ({m0, busy_w[0]} !== {32'h200, 1'b1}) begin
      n_fail++;
      $display("FAIL sweep_cycle10 got m=%h busy=%b exp m=%h busy=1", m0, busy_w[0], 32'h200);
    end
    tick();
    n_checks++;
    if ({m0, st0} !== {32'h0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_mid_sweep got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h0, 4'b0000);
    end
    drive(1'b0, 1'b1, 1'b0, 8'd2);
    tick();
    n_checks++;
    if ({m0, st0} !== {32'h4, 4'b1000}) begin
      n_fail++;
      $display("FAIL decode_after_abort got m=%h st=%b exp m=%h st=%b", m0, st0, 32'h4, 4'b1000);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({m0, st0} !== {32'h0, 4'b0000}) begin
        n_fail++;
        $display("FAIL no_resume i=%0d got m=%h st=%b exp zero", i, m0, st0);
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] am;
    exp_t         got;
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      model_step();
      tick();
      for (int d = 0; d < NDUT; d++) begin
        am  = get_m(d);
        got = {am, valid_w[d], masked_w[d], busy_w[d], done_w[d]};
        n_checks++;
        if (got !== exp_q[d]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc=%0d got m=%h vkbd=%b%b%b%b exp m=%h vkbd=%b%b%b%b",
                   d, cyc, got.m, got.valid, got.masked, got.busy, got.done,
                   exp_q[d].m, exp_q[d].valid, exp_q[d].masked, exp_q[d].busy, exp_q[d].done);
        end
        n_checks++;
        if ($countones(am) > 1) begin
          n_fail++;
          $display("FAIL onehot dut%0d cyc=%0d got m=%h exp at most one bit", d, cyc, am);
        end
      end
      drive(($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    for (int d = 0; d < NDUT; d++) begin
      sw_pos[d] = -1;
      exp_q[d]  = '0;
    end
    test_reset();
    test_decode();
    test_sweep();
    test_collision();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
